// File: rtl/conv_window_sequencer.sv
// Address and strobe sequencer for one 2-D convolution pass over a square image.
// Optional build macro CONV_STRIDE2_EN selects a window step of 2 in both directions.
module conv_window_sequencer #(
  parameter int IMG_SIZE = 256,
  parameter int KER_SIZE = 3,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] imAddr,
  output logic [ADDR_W-1:0] kAddr,
  output logic [ADDR_W-1:0] filtAddr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              out_we,
  output logic              busy,
  output logic              done
);

`ifdef CONV_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int OUT = (IMG_SIZE - KER_SIZE) / STRIDE + 1;

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(KER_SIZE - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT - 1);
  localparam logic [ADDR_W-1:0] IMG_STEP = ADDR_W'(IMG_SIZE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_SIZE);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_im_addr, r_k_addr, r_filt_addr;
  logic [ADDR_W-1:0] r_row_base, r_pix_base, r_win_row;
  logic [ADDR_W-1:0] r_r, r_c, r_kr, r_kc;
  logic              r_mac_en, r_mac_clr;
  logic              w_last_tap, w_last_pix;

  assign w_last_tap = (r_kr == K_LAST) && (r_kc == K_LAST);
  assign w_last_pix = (r_r == OUT_LAST) && (r_c == OUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    out_we = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: if (w_last_tap) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: begin
        out_we = 1'b1;
        if (out_ready) w_next = w_last_pix ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Window walk: r_win_row tracks the image address of the current kernel row start.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE || r_state == S_DONE) begin
      r_im_addr   <= '0;
      r_k_addr    <= '0;
      r_filt_addr <= '0;
      r_row_base  <= '0;
      r_pix_base  <= '0;
      r_win_row   <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
    end else if (r_state == S_FETCH && !w_last_tap) begin
      r_k_addr <= r_k_addr + 1'b1;
      if (r_kc == K_LAST) begin
        r_kc      <= '0;
        r_kr      <= r_kr + 1'b1;
        r_win_row <= r_win_row + IMG_STEP;
        r_im_addr <= r_win_row + IMG_STEP;
      end else begin
        r_kc      <= r_kc + 1'b1;
        r_im_addr <= r_im_addr + 1'b1;
      end
    end else if (r_state == S_WRITE && out_ready && !w_last_pix) begin
      r_kr        <= '0;
      r_kc        <= '0;
      r_k_addr    <= '0;
      r_filt_addr <= r_filt_addr + 1'b1;
      if (r_c == OUT_LAST) begin
        r_c        <= '0;
        r_r        <= r_r + 1'b1;
        r_row_base <= r_row_base + ROW_STEP;
        r_pix_base <= r_row_base + ROW_STEP;
        r_win_row  <= r_row_base + ROW_STEP;
        r_im_addr  <= r_row_base + ROW_STEP;
      end else begin
        r_c        <= r_c + 1'b1;
        r_pix_base <= r_pix_base + COL_STEP;
        r_win_row  <= r_pix_base + COL_STEP;
        r_im_addr  <= r_pix_base + COL_STEP;
      end
    end
  end

  // Read data arrives one cycle after the address, so the MAC strobes lag the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      r_mac_en  <= (r_state == S_FETCH);
      r_mac_clr <= (r_state == S_FETCH) && (r_kr == '0) && (r_kc == '0);
    end
  end

  assign imAddr   = r_im_addr;
  assign kAddr    = r_k_addr;
  assign filtAddr = r_filt_addr;
  assign mac_en   = r_mac_en;
  assign mac_clr  = r_mac_clr;

endmodule
